div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle iterative integer divider; inverse-operation companion to the datapath ALU multiply op.
- Decoded DIV/DIVU instructions hand operands to this block through a start/done handshake.
- Pipeline control stalls while busy_o is high.
- Restoring algorithm; one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits. Iteration counter width is ceil(log2(WIDTH))+1.

Ports:
- clk_i  input  1  system clock, all state updates on the rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request a division; sampled only when busy_o=0
- signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start_i
- src1_i  input  WIDTH  dividend; captured with start_i
- src2_i  input  WIDTH  divisor; captured with start_i
- busy_o  output  1  high in CALC and FIX states
- done_o  output  1  one-cycle pulse when results become valid
- quotient_o  output  WIDTH  quotient, held until the next accepted start
- remainder_o  output  WIDTH  remainder, held until the next accepted start
- div_zero_o  output  1  divisor was zero for the current result, held with results

Behaviour:
- States: IDLE, CALC, FIX, DONE.

Reset:
- rst_i=1 at any edge forces IDLE and clears counter and internal registers.
- Outputs after reset: busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_zero_o=0.
- Applies mid-operation; the aborted division produces no done_o.

Accept:
- start_i is accepted in IDLE or DONE only; start_i in CALC/FIX is ignored.
- On accept, operands and signed_i are captured.
- In signed mode, the magnitudes of both operands are taken and two sign flags stored: quotient sign = src1[MSB]^src2[MSB], remainder sign = src1[MSB].
- Result outputs are cleared to 0 on accept.

Divide by zero:
- src2_i==0 at accept goes directly to DONE on the next edge.
- Results: quotient_o=all ones, remainder_o=src1_i (raw, unmodified), div_zero_o=1.
- Signed mode does not alter these values.

CALC:
- WIDTH iterations.
- Each iteration: the partial remainder (WIDTH+1 bits) shifts left, taking the next dividend MSB.
- Then the divisor magnitude is subtracted.
- If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- Counter runs 0..WIDTH-1, then the block moves to FIX.

FIX:
- One cycle. Negate quotient/remainder per the stored sign flags (signed mode only).
- Load quotient_o/remainder_o, then go to DONE.
- INT_MIN / -1: the negated magnitude wraps to 0x80000000, remainder 0; no error flag.

DONE:
- done_o=1 for exactly one cycle.
- Next state is IDLE, or a new accept if start_i=1 (back-to-back allowed).

Latency:
- start_i accepted at the end of cycle 0.
- CALC occupies cycles 1..32 and FIX cycle 33.
- done_o=1 in cycle 34 (WIDTH+2 after accept).
- Divide-by-zero: done_o=1 in cycle 1.

Reset vs start:
- rst_i and start_i asserted together: reset wins and the start is dropped.

Output validity:
- Outputs change only on accept (cleared), in FIX (loaded), on the divide-by-zero path, or on reset.

Test Plan:
- Unsigned 100/7, start at cycle 0 -> busy_o cycles 1-33, done_o cycle 34 only, quotient_o=14, remainder_o=2, div_zero_o=0.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient_o=0xFFFFFFFD, remainder_o=0xFFFFFFFF. Signed 7/-2 -> 0xFFFFFFFD, 0x00000001.
- Edge operands:
  - Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
  - Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
  - Unsigned 3/10 -> quotient 0, remainder 3.
- Divide-by-zero, 5/0 with signed_i=1 -> done_o in cycle 1, quotient_o=0xFFFFFFFF, remainder_o=5, div_zero_o=1; the next normal division clears div_zero_o.
- Start during busy: start 100/7 at cycle 0, start 9/3 at cycle 5 -> second request ignored, cycle 34 result 14/2. Start 9/3 in the done cycle -> accepted, done_o at cycle 68 with 3/0.
- Reset mid-op: rst_i=1 in cycle 10 of a division -> cycle 11 shows IDLE with all outputs 0, no done_o pulse; a new start then completes normally in 34 cycles.

Source files
------------

// File: rtl/div_unit_if.sv
// Operand/result bundle between instruction decode and the iterative divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] quotient_o;
  logic [WIDTH-1:0] remainder_o;
  logic             div_zero_o;

  modport master (
    output start_i, signed_i, src1_i, src2_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );

  modport slave (
    input  start_i, signed_i, src1_i, src2_i,
    output busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring integer divider (DIV/DIVU), one quotient bit per clock.
// Signed operands are divided as magnitudes and the signs applied in one fix-up cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   rem_diff_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  // dvd_q holds the unconsumed dividend bits at the top and collects quotient bits at the bottom
  assign rem_shift_s = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign rem_diff_s  = rem_shift_s - {1'b0, dvs_q};

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          q_neg_d = bus.signed_i & (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
          r_neg_d = bus.signed_i & bus.src1_i[WIDTH-1];
          if (bus.src2_i == {WIDTH{1'b0}}) begin
            state_d = DONE;
            quot_d  = {WIDTH{1'b1}};
            remo_d  = bus.src1_i;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = {CW{1'b0}};
            rem_d   = {(WIDTH+1){1'b0}};
            dvd_d   = magnitude(bus.src1_i, bus.signed_i);
            dvs_d   = magnitude(bus.src2_i, bus.signed_i);
            quot_d  = {WIDTH{1'b0}};
            remo_d  = {WIDTH{1'b0}};
            dz_d    = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (!rem_diff_s[WIDTH]) begin
          rem_d = rem_diff_s;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift_s;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      FIX: begin
        quot_d  = q_neg_q ? negate(dvd_q) : dvd_q;
        remo_d  = r_neg_q ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      dvd_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      rem_q   <= {(WIDTH+1){1'b0}};
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= {WIDTH{1'b0}};
      remo_q  <= {WIDTH{1'b0}};
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.quotient_o  = quot_q;
  assign bus.remainder_o = remo_q;
  assign bus.div_zero_o  = dz_q;

endmodule
